// File: rtl/tipi_rb_pkg.sv
// Shared types and constants for the TI/Pi readback arbiter.
package tipi_rb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic       REQ_TI = 1'b0;
  localparam logic       REQ_PI = 1'b1;

  localparam logic [1:0] REG_TD = 2'd0;
  localparam logic [1:0] REG_TC = 2'd1;
  localparam logic [1:0] REG_RD = 2'd2;
  localparam logic [1:0] REG_RC = 2'd3;

  // Bit 0 drives a_addr (TD) through bit 3 driving d_addr (RC).
  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    logic [3:0] v;
    v      = 4'b0000;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tipi_readback_arbiter.sv
// Round-robin sequencer sharing the one-hot readback mux between the TI bus
// read path and the Pi read port: grant, hold selects, capture, ack, release.
module tipi_readback_arbiter
  import tipi_rb_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ti_req,
  input  logic [1:0] i_ti_sel,
  output logic       o_ti_ack,
  output logic [7:0] o_ti_data,
  input  logic       i_pi_req,
  input  logic [1:0] i_pi_sel,
  output logic       o_pi_ack,
  output logic [7:0] o_pi_data,
  output logic       o_a_addr,
  output logic       o_b_addr,
  output logic       o_c_addr,
  output logic       o_d_addr,
  input  logic [7:0] i_mux_o,
  output logic       o_busy
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_win;
  logic [3:0]    r_sels;
  logic          r_ti_ack;
  logic          r_pi_ack;
  logic [7:0]    r_ti_data;
  logic [7:0]    r_pi_data;
  logic          r_busy;

  logic          w_any;
  logic          w_win;
  logic [1:0]    w_sel;

  // On a tie the requester not granted last wins; a lone request always wins.
  always_comb begin
    w_any = i_ti_req | i_pi_req;
    w_win = r_last;
    if (i_ti_req && i_pi_req) w_win = ~r_last;
    else if (i_ti_req)        w_win = REQ_TI;
    else if (i_pi_req)        w_win = REQ_PI;
    w_sel = (w_win == REQ_TI) ? i_ti_sel : i_pi_sel;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= REQ_PI;
      r_win     <= REQ_TI;
      r_sels    <= '0;
      r_ti_ack  <= 1'b0;
      r_pi_ack  <= 1'b0;
      r_ti_data <= '0;
      r_pi_data <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_ti_ack <= 1'b0;
      r_pi_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= SELECT;
            r_win   <= w_win;
            r_last  <= w_win;
            r_sels  <= onehot4(w_sel);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SELECT: begin
          // Last hold cycle: sample the settled mux and drop the selects.
          if (r_cnt == CW'(SETTLE)) begin
            r_state <= RELEASE;
            r_sels  <= '0;
            if (r_win == REQ_TI) begin
              r_ti_data <= i_mux_o;
              r_ti_ack  <= 1'b1;
            end else begin
              r_pi_data <= i_mux_o;
              r_pi_ack  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RELEASE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_sels  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ti_ack  = r_ti_ack;
  assign o_pi_ack  = r_pi_ack;
  assign o_ti_data = r_ti_data;
  assign o_pi_data = r_pi_data;
  assign o_a_addr  = r_sels[0];
  assign o_b_addr  = r_sels[1];
  assign o_c_addr  = r_sels[2];
  assign o_d_addr  = r_sels[3];
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_tipi_readback_arbiter.sv
// Bench for tipi_readback_arbiter: directed scenarios with literal checks plus
// a randomized phase, all shadowed by a transaction-timing model.
module tb_tipi_readback_arbiter;

  localparam int S = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ti_req = 1'b0, pi_req = 1'b0;
  logic [1:0] ti_sel = 2'd0, pi_sel = 2'd0;
  logic       ti_ack, pi_ack, a_addr, b_addr, c_addr, d_addr, busy;
  logic [7:0] ti_data, pi_data, mux_o;
  logic [3:0] sels;

  int checks = 0;
  int failures = 0;

  assign sels  = {d_addr, c_addr, b_addr, a_addr};
  assign mux_o = a_addr ? 8'haa : b_addr ? 8'hbb : c_addr ? 8'hcc : d_addr ? 8'hdd : 8'h00;

  always #5 clk = ~clk;

  tipi_readback_arbiter #(.SETTLE(S)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_ti_req(ti_req), .i_ti_sel(ti_sel), .o_ti_ack(ti_ack), .o_ti_data(ti_data),
    .i_pi_req(pi_req), .i_pi_sel(pi_sel), .o_pi_ack(pi_ack), .o_pi_data(pi_data),
    .o_a_addr(a_addr), .o_b_addr(b_addr), .o_c_addr(c_addr), .o_d_addr(d_addr),
    .i_mux_o(mux_o), .o_busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] regval(input logic [1:0] s);
    case (s)
      2'd0:    return 8'haa;
      2'd1:    return 8'hbb;
      2'd2:    return 8'hcc;
      default: return 8'hdd;
    endcase
  endfunction

  // Transaction model: age counts cycles since the grant cycle (age 0).
  // Selects at ages 1..S+1, ack at S+2, idle again from S+3.
  bit         m_valid = 0;
  bit         m_act = 0;
  int         m_age = 0;
  int         m_who = 0;
  int         m_last = 1;
  logic [1:0] m_sel = 2'd0;
  logic [7:0] m_td = 8'h00, m_pd = 8'h00;

  always @(negedge clk) begin : model
    logic [3:0] e_sels;
    logic       e_ta, e_pa, e_busy;
    bit         idle;
    if (m_valid) begin
      e_sels = 4'b0000;
      if (m_act && m_age >= 1 && m_age <= S + 1) e_sels[m_sel] = 1'b1;
      e_ta   = m_act && (m_age == S + 2) && (m_who == 0);
      e_pa   = m_act && (m_age == S + 2) && (m_who == 1);
      e_busy = m_act && (m_age >= 1) && (m_age <= S + 2);
      if (e_ta) m_td = regval(m_sel);
      if (e_pa) m_pd = regval(m_sel);
      chk("m_sels", sels, e_sels);
      chk("m_ti_ack", ti_ack, e_ta);
      chk("m_pi_ack", pi_ack, e_pa);
      chk("m_busy", busy, e_busy);
      chk("m_ti_data", ti_data, m_td);
      chk("m_pi_data", pi_data, m_pd);
      chk("onehot", ($countones(sels) <= 1), 1);
    end
    if (!reset_n) begin
      m_valid = 1; m_act = 0; m_age = 0; m_td = 8'h00; m_pd = 8'h00; m_last = 1;
    end else if (m_valid) begin
      idle = !m_act || (m_age >= S + 3);
      if (idle && (ti_req || pi_req)) begin
        m_who  = (ti_req && pi_req) ? (1 - m_last) : (ti_req ? 0 : 1);
        m_last = m_who;
        m_sel  = (m_who == 0) ? ti_sel : pi_sel;
        m_act  = 1;
        m_age  = 1;
      end else if (m_act) begin
        m_age++;
        if (m_age >= S + 3) m_act = 0;
      end
    end
  end

  task automatic tk();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; ti_req = 1'b0; pi_req = 1'b0;
    tk(); tk();
    @(negedge clk);
    chk("rst_sels", sels, 4'b0000);
    chk("rst_acks", {ti_ack, pi_ack}, 2'b00);
    chk("rst_ti_data", ti_data, 8'h00);
    chk("rst_pi_data", pi_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    tk();
    reset_n = 1'b1;
  endtask

  initial begin : stim
    int ord[6];
    int exp_ord[6];
    int n;
    logic ta, pa;
    exp_ord = '{0, 1, 0, 1, 0, 1};

    #1;
    do_reset();

    // Single TI read of RD.
    ti_req = 1; ti_sel = 2'd2;
    @(negedge clk); chk("t1_busy0", busy, 1'b0);
    tk(); @(negedge clk); chk("t1_sel_c1", sels, 4'b0100);
    tk(); @(negedge clk); chk("t1_sel_c2", sels, 4'b0100);
    tk(); @(negedge clk);
    chk("t1_ack", ti_ack, 1'b1); chk("t1_data", ti_data, 8'hcc); chk("t1_sel_c3", sels, 4'b0000);
    tk(); ti_req = 0;
    @(negedge clk); chk("t1_busy4", busy, 1'b0);
    tk();

    // Simultaneous requests from reset: TI first, then Pi.
    do_reset();
    ti_req = 1; ti_sel = 2'd0; pi_req = 1; pi_sel = 2'd3;
    tk(); tk(); tk(); @(negedge clk);
    chk("t2_ti_ack", ti_ack, 1'b1); chk("t2_ti_data", ti_data, 8'haa); chk("t2_pi_ack3", pi_ack, 1'b0);
    tk(); ti_req = 0;
    @(negedge clk); chk("t2_busy4", busy, 1'b0);
    tk(); @(negedge clk); chk("t2_sel_c5", sels, 4'b1000);
    tk(); @(negedge clk); chk("t2_sel_c6", sels, 4'b1000);
    tk(); @(negedge clk);
    chk("t2_pi_ack", pi_ack, 1'b1); chk("t2_pi_data", pi_data, 8'hdd); chk("t2_ti_hold", ti_data, 8'haa);
    tk(); pi_req = 0;
    tk();

    // Fairness with both requests held continuously.
    ti_req = 1; pi_req = 1; ti_sel = 2'd1; pi_sel = 2'd2;
    n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      @(negedge clk);
      if (ti_ack) begin ord[n] = 0; n++; end
      else if (pi_ack) begin ord[n] = 1; n++; end
      if (n < 6) tk();
    end
    tk(); ti_req = 0; pi_req = 0;
    chk("fair_count", n, 6);
    for (int i = 0; i < 6; i++) if (i < n) chk("fair_order", ord[i], exp_ord[i]);
    tk(); tk();

    // Sel change after grant is ignored.
    ti_req = 1; ti_sel = 2'd1;
    @(negedge clk); chk("t4_sel_c0", sels, 4'b0000);
    tk(); ti_sel = 2'd3;
    @(negedge clk); chk("t4_sel_c1", sels, 4'b0010);
    tk(); @(negedge clk); chk("t4_sel_c2", sels, 4'b0010);
    tk(); @(negedge clk); chk("t4_ack", ti_ack, 1'b1); chk("t4_data", ti_data, 8'hbb);
    tk(); ti_req = 0;
    tk();

    // Reset in the middle of a Pi read.
    pi_req = 1; pi_sel = 2'd2;
    tk(); reset_n = 0;
    @(negedge clk); chk("t5_sel_c1", sels, 4'b0100);
    tk(); reset_n = 1; pi_req = 0;
    @(negedge clk);
    chk("t5_sel_off", sels, 4'b0000); chk("t5_busy", busy, 1'b0); chk("t5_pi_data", pi_data, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tk(); @(negedge clk); chk("t5_no_ack", pi_ack, 1'b0);
    end
    tk();
    ti_req = 1; ti_sel = 2'd3; pi_req = 1; pi_sel = 2'd0;
    tk(); tk(); tk(); @(negedge clk);
    chk("t5_ti_first", ti_ack, 1'b1); chk("t5_pi_not", pi_ack, 1'b0); chk("t5_ti_data", ti_data, 8'hdd);
    tk(); ti_req = 0; pi_req = 0;
    tk(); tk();

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); ta = ti_ack; pa = pi_ack;
      tk();
      reset_n = ($urandom_range(0, 199) != 0);
      if (ta) ti_req = 0;
      else if (!ti_req) ti_req = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 19) == 0) ti_req = 0;
      if (pa) pi_req = 0;
      else if (!pi_req) pi_req = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 19) == 0) pi_req = 0;
      if ($urandom_range(0, 3) == 0) ti_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) pi_sel = 2'($urandom_range(0, 3));
    end
    reset_n = 1; ti_req = 0; pi_req = 0;
    tk(); tk(); tk(); tk(); tk();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tipi_readback_arbiter.md
# tipi_readback_arbiter

Sequencer and arbiter for the 4:1 one-hot register readback mux (TD, TC, RD, RC; output 8'h00 when no select is asserted). Two requesters share the mux: the TI bus read path and the Raspberry Pi read port. The block grants one requester at a time and drives the mux one-hot selects. It holds the selects for a configurable settle time, captures the mux output into a per-requester data register, acknowledges the requester, then releases the mux. It sits in the PEB top level between the address decode / Pi shift logic and the existing readback mux.

## Interface
- SETTLE, 1, extra cycles the selects are held before capture (0..15); total select hold = SETTLE+1 cycles
- clk  in  1  system clock; the only clock
- reset_n  in  1  reset, synchronous, active-low
- ti_req  in  1  TI read request, level, already synchronized to clk
- ti_sel  in  2  TI register index: 0=TD(a) 1=TC(b) 2=RD(c) 3=RC(d)
- ti_ack  out  1  one-cycle pulse; ti_data is valid from this cycle on
- ti_data  out  8  last value captured for TI
- pi_req  in  1  Pi read request, level, synchronized
- pi_sel  in  2  Pi register index, same encoding as ti_sel
- pi_ack  out  1  one-cycle pulse; pi_data is valid from this cycle on
- pi_data  out  8  last value captured for Pi
- a_addr, b_addr, c_addr, d_addr  out  1 each  one-hot mux selects, all registered
- mux_o  in  8  readback mux output
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, SELECT, RELEASE.
  - IDLE → SELECT when any request is present.
  - SELECT → RELEASE after SETTLE+1 cycles, counted by the settle counter.
  - RELEASE → IDLE unconditionally.
- Requests are sampled only in IDLE. Arbitration is round-robin with a last-grant pointer:
  - On a tie, the requester not granted last wins.
  - With a single request, that requester wins regardless of the pointer.
  - The pointer updates at each grant.
- At grant, the winner's sel is latched. Changes to ti_sel or pi_sel after grant are ignored until the next grant.
- In SELECT, exactly the latched select is high. In IDLE and RELEASE, all selects are 0. At most one select is high in any cycle.
- At the final SELECT edge, mux_o is captured into the winner's data register. The matching ack pulses for the single RELEASE cycle.
- A data register changes only on its own capture and holds its value otherwise.
- A requester keeps req high until its ack and deasserts it in the cycle after ack. Req still high in the IDLE cycle after RELEASE is treated as a new request.
- If one requester's req drops before grant, the request is lost, with no ack. Dropping req after grant has no effect; the transaction completes and acks.

## Timing
- Reset values: ti_ack=pi_ack=0, ti_data=pi_data=8'h00, all selects 0, busy=0, state IDLE, pointer=Pi (TI wins the first tie).
- Request seen in IDLE at cycle N:
  - selects high in cycles N+1 .. N+1+SETTLE;
  - capture at the end of cycle N+1+SETTLE;
  - ack, updated data and all-zero selects in cycle N+2+SETTLE;
  - IDLE in N+3+SETTLE.
- SETTLE=1: request in cycle 0 → ack in cycle 3. The next grant is sampled in cycle 4, giving a minimum transaction period of SETTLE+3.
- Settle counter width is $clog2(SETTLE+1), minimum 1 bit. SETTLE=0 holds the selects for exactly one cycle.
- reset_n low in any cycle:
  - at the next edge, all outputs take their reset values and state returns to IDLE;
  - an in-flight transaction is discarded with no ack and no capture.
- Simultaneous ack and a new req from the other requester: the new req is serviced after RELEASE. No overlap is allowed.

## Structure
- Package tipi_rb_pkg holds:
  - state enum (IDLE, SELECT, RELEASE);
  - requester index constants (REQ_TI=0, REQ_PI=1);
  - register index constants (REG_TD=0, REG_TC=1, REG_RD=2, REG_RC=3);
  - function onehot4(sel) returning the 4-bit select vector.
- No sub-module. The arbiter and FSM form one module, and the parent instantiates the existing readback mux alongside it.

## Test plan
All scenarios use SETTLE=1. The bench models the readback mux with a=8'haa, b=8'hbb, c=8'hcc, d=8'hdd, and asserts "at most one select high" every cycle throughout.

- Reset: hold reset_n=0 for 2 cycles → all selects 0, acks 0, ti_data=pi_data=8'h00, busy=0.
- Single TI read: ti_req=1, ti_sel=2 at cycle 0 → c_addr=1 in cycles 1–2, ti_ack and ti_data=8'hcc in cycle 3 with all selects 0, busy=0 in cycle 4.
- Simultaneous requests, TI ti_sel=0 and Pi pi_sel=3 at cycle 0 → ti_ack with 8'haa in cycle 3; Pi granted in cycle 4; pi_ack with pi_data=8'hdd in cycle 7; ti_data stays 8'haa.
- Fairness: both reqs re-raised immediately after each ack for 6 transactions → grant order TI, Pi, TI, Pi, TI, Pi.
- Sel change mid-transaction: ti_sel=1 at grant, switched to 3 in cycle 1 → ti_data=8'hbb and only b_addr ever high.
- Reset mid-operation: reset_n=0 during cycle 1 of a Pi read → selects 0 the next cycle, no pi_ack, pi_data=8'h00. Afterwards, simultaneous requests grant TI first.
